lcd_hd44780_sequencer: RTL

- Sequences the 8-bit HD44780-compatible character LCD behind the RS/RW/E/data[7:0] pins.
- Runs the mandatory power-up initialisation by itself, then accepts command/data bytes over a valid/ready handshake.
- Generates E pulses with setup/hold timing and enforces per-instruction execution delays.
- Sits between the CPU-side register logic and the LCD pins, so software never bit-bangs timing.

---
 rtl/lcd_hd44780_sequencer_if.sv | 12 +
 rtl/lcd_hd44780_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_sequencer_if.sv
// Write channel between the CPU-side register logic and the HD44780 sequencer.
// The master offers a command/data byte with wr_valid. The slave accepts it
// on any cycle where wr_valid && wr_ready.
interface lcd_hd44780_sequencer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_hd44780_sequencer.sv
// HD44780 8-bit LCD sequencer.
// Runs the power-up init ROM by itself, then forwards accepted command/data
// bytes to the LCD pins. Every write gets E setup/high/hold timing followed by
// an execution wait.
// Optional macro LCD_BUSY_POLL_EN: once init is complete, the fixed execution
// wait is replaced by busy-flag reads. If the flag stays set, the reads stop
// after the normal fixed wait and the block returns to IDLE anyway.
module lcd_hd44780_sequencer #(
  parameter int unsigned T_SETUP_CYC      = 3,
  parameter int unsigned E_HIGH_CYC       = 25,
  parameter int unsigned HOLD_CYC         = 3,
  parameter int unsigned CMD_WAIT_CYC     = 2500,
  parameter int unsigned CLEAR_WAIT_CYC   = 100000,
  parameter int unsigned INIT_WAIT_CYC    = 250000,
  parameter int unsigned POWERON_WAIT_CYC = 2000000,
  parameter int unsigned CNT_W            = 24
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  lcd_hd44780_sequencer_if.slave       bus,
  output logic                         init_done,
  output logic                         busy,
  output logic                         lcd_RS,
  output logic                         lcd_RW,
  output logic                         lcd_E,
  inout  wire  [7:0]                   lcd_data
);

  localparam longint unsigned CNT_CAP = 64'd1 << CNT_W;

  // Every delay counter loads N-1, so zero or oversized delays cannot be represented.
  generate
    if (T_SETUP_CYC == 0 || E_HIGH_CYC == 0 || HOLD_CYC == 0 || CMD_WAIT_CYC == 0 ||
        CLEAR_WAIT_CYC == 0 || INIT_WAIT_CYC == 0 || POWERON_WAIT_CYC == 0) begin : g_zero_param
      $error("lcd_hd44780_sequencer: timing parameters must be non-zero");
    end
    if (longint'(POWERON_WAIT_CYC) > CNT_CAP || longint'(INIT_WAIT_CYC) > CNT_CAP ||
        longint'(CLEAR_WAIT_CYC) > CNT_CAP || longint'(CMD_WAIT_CYC) > CNT_CAP) begin : g_cnt_width
      $error("lcd_hd44780_sequencer: CNT_W too narrow for the wait parameters");
    end
  endgenerate

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_HIGH_LD  = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD     = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD   = CNT_W'(CLEAR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_LD    = CNT_W'(INIT_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(POWERON_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    PWRUP_WAIT, INIT_LOAD, SETUP, E_HIGH, HOLD, EXEC_WAIT, IDLE
  } state_t;

  // Clear/home instructions (0x01..0x03 with rs=0) need the long execution wait.
  function automatic logic [CNT_W-1:0] exec_wait(input logic rs, input logic [7:0] data);
    if (!rs && data >= 8'h01 && data <= 8'h03) begin
      return CLEAR_LD;
    end else begin
      return CMD_LD;
    end
  endfunction

  function automatic logic [7:0] init_rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h38;
      3'd4:             return 8'h08;
      3'd5:             return 8'h01;
      3'd6:             return 8'h06;
      3'd7:             return 8'h0C;
      default:          return 8'h30;
    endcase
  endfunction

  // The first two 0x30 writes need the long wait; the rest follow the usual rule.
  function automatic logic [CNT_W-1:0] init_rom_wait(input logic [2:0] idx);
    if (idx == 3'd0 || idx == 3'd1) begin
      return INIT_LD;
    end else begin
      return exec_wait(1'b0, init_rom_byte(idx));
    end
  endfunction

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic [CNT_W-1:0] wait_r, wait_nxt;
  logic [7:0]       data_r, data_nxt;
  logic             rs_r, rs_nxt;
  logic             e_r, e_nxt;
  logic [2:0]       idx_r, idx_nxt;
  logic             init_done_r, init_done_nxt;
  logic             ready_r;
  logic             busy_r;
  logic             cnt_zero_s;
  logic             hs_s;
`ifdef LCD_BUSY_POLL_EN
  logic             rw_r, rw_nxt;
  logic             drv_r, drv_nxt;
  logic             poll_r, poll_nxt;
  logic             bf_r, bf_nxt;
  logic [CNT_W-1:0] poll_cnt_r, poll_cnt_nxt;
`endif

  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
  assign hs_s       = bus.wr_valid && ready_r;

  // Next-state and next-register-value logic for the sequencer FSM.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_zero_s ? cnt_r : (cnt_r - CNT_W'(1));
    wait_nxt      = wait_r;
    data_nxt      = data_r;
    rs_nxt        = rs_r;
    e_nxt         = e_r;
    idx_nxt       = idx_r;
    init_done_nxt = init_done_r;
`ifdef LCD_BUSY_POLL_EN
    rw_nxt        = rw_r;
    drv_nxt       = drv_r;
    poll_nxt      = poll_r;
    bf_nxt        = bf_r;
    poll_cnt_nxt  = poll_r ? (poll_cnt_r + CNT_W'(1)) : poll_cnt_r;
`endif
    case (state_r)
      PWRUP_WAIT: begin
        // Counts up from the reset value 0, so the wait lasts POWERON_WAIT_CYC cycles.
        if (cnt_r == PWRUP_LAST) begin
          state_nxt = INIT_LOAD;
          cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt   = cnt_r + CNT_W'(1);
        end
      end
      INIT_LOAD: begin
        data_nxt  = init_rom_byte(idx_r);
        rs_nxt    = 1'b0;
        wait_nxt  = init_rom_wait(idx_r);
        cnt_nxt   = SETUP_LD;
        state_nxt = SETUP;
      end
      SETUP: begin
        if (cnt_zero_s) begin
          e_nxt     = 1'b1;
          cnt_nxt   = E_HIGH_LD;
          state_nxt = E_HIGH;
        end else begin
          state_nxt = SETUP;
        end
      end
      E_HIGH: begin
        if (cnt_zero_s) begin
`ifdef LCD_BUSY_POLL_EN
          bf_nxt    = poll_r ? lcd_data[7] : bf_r;
`endif
          e_nxt     = 1'b0;
          cnt_nxt   = HOLD_LD;
          state_nxt = HOLD;
        end else begin
          state_nxt = E_HIGH;
        end
      end
      HOLD: begin
        if (cnt_zero_s) begin
`ifdef LCD_BUSY_POLL_EN
          if (poll_r) begin
            if (!bf_r || poll_cnt_r >= wait_r) begin
              poll_nxt  = 1'b0;
              rw_nxt    = 1'b0;
              drv_nxt   = 1'b1;
              state_nxt = IDLE;
            end else begin
              cnt_nxt   = SETUP_LD;
              state_nxt = SETUP;
            end
          end else if (init_done_r) begin
            poll_nxt     = 1'b1;
            poll_cnt_nxt = {CNT_W{1'b0}};
            rw_nxt       = 1'b1;
            drv_nxt      = 1'b0;
            rs_nxt       = 1'b0;
            cnt_nxt      = SETUP_LD;
            state_nxt    = SETUP;
          end else begin
            cnt_nxt   = wait_r;
            state_nxt = EXEC_WAIT;
          end
`else
          cnt_nxt   = wait_r;
          state_nxt = EXEC_WAIT;
`endif
        end else begin
          state_nxt = HOLD;
        end
      end
      EXEC_WAIT: begin
        if (!cnt_zero_s) begin
          state_nxt = EXEC_WAIT;
        end else if (init_done_r) begin
          state_nxt = IDLE;
        end else if (idx_r == 3'd7) begin
          init_done_nxt = 1'b1;
          state_nxt     = IDLE;
        end else begin
          idx_nxt   = idx_r + 3'd1;
          state_nxt = INIT_LOAD;
        end
      end
      IDLE: begin
        if (hs_s) begin
          data_nxt  = bus.wr_data;
          rs_nxt    = bus.wr_rs;
          wait_nxt  = exec_wait(bus.wr_rs, bus.wr_data);
          cnt_nxt   = SETUP_LD;
          state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = PWRUP_WAIT;
        cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers; ready/busy are registered from the next state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r     <= PWRUP_WAIT;
      cnt_r       <= {CNT_W{1'b0}};
      wait_r      <= {CNT_W{1'b0}};
      data_r      <= 8'h00;
      rs_r        <= 1'b0;
      e_r         <= 1'b0;
      idx_r       <= 3'd0;
      init_done_r <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
      rw_r        <= 1'b0;
      drv_r       <= 1'b1;
      poll_r      <= 1'b0;
      bf_r        <= 1'b0;
      poll_cnt_r  <= {CNT_W{1'b0}};
`endif
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      wait_r      <= wait_nxt;
      data_r      <= data_nxt;
      rs_r        <= rs_nxt;
      e_r         <= e_nxt;
      idx_r       <= idx_nxt;
      init_done_r <= init_done_nxt;
      ready_r     <= (state_nxt == IDLE);
      busy_r      <= (state_nxt != IDLE);
`ifdef LCD_BUSY_POLL_EN
      rw_r        <= rw_nxt;
      drv_r       <= drv_nxt;
      poll_r      <= poll_nxt;
      bf_r        <= bf_nxt;
      poll_cnt_r  <= poll_cnt_nxt;
`endif
    end
  end

  assign bus.wr_ready = ready_r;
  assign init_done    = init_done_r;
  assign busy         = busy_r;
  assign lcd_RS       = rs_r;
  assign lcd_E        = e_r;
`ifdef LCD_BUSY_POLL_EN
  assign lcd_RW       = rw_r;
  assign lcd_data     = drv_r ? data_r : 8'hzz;
`else
  assign lcd_RW       = 1'b0;
  assign lcd_data     = data_r;
`endif

endmodule
